// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC/fetch sequencer: FSM encoding, fault causes, word size.
// Pure declarations; no latency or flow-control behaviour of its own.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic FAULT_TIMEOUT  = 1'b0;
  localparam logic FAULT_MISALIGN = 1'b1;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned TO_CNT_W   = 8;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] instr_index);
    return {pc_plus4[31:28], instr_index, 2'b00};
  endfunction

  function automatic logic word_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selection: jump_reg > jump > branch > sequential, plus jr alignment flag.
// Purely combinational, zero latency; no flow control.
module pc_fetch_unit_next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] se_immediate,
  input  logic [25:0] instr_index,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] branch_target;

  // Word offset scaled to bytes; overflow wraps silently.
  assign branch_target = pc_plus4 + (se_immediate << 2);

  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    if (jump_reg) begin
      next_pc    = jr_addr;
      misaligned = word_misaligned(jr_addr[1:0]);
    end else if (jump) begin
      next_pc = jump_target(pc_plus4, instr_index);
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction register and req/ack fetch FSM with ack-timeout and jr-alignment faults.
// Fetch latency >= 1 cycle after retire; stall holds the instruction, imem_req waits on imem_ack.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] immediate,
  input  logic [31:0] se_immediate,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
  input  logic        advance,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault,
  output logic        fault_cause
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic                started_q;
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic [31:0]         pc_q;
  logic [31:0]         instr_q;
  logic                instr_valid_q;
  logic                fault_q;
  logic                cause_q;

  logic [31:0] next_pc;
  logic        misaligned;
  logic        fetch_done;
  logic        req_wait;
  logic        timeout_hit;
  logic        retire_ok;
  logic        retire_bad;

  pc_fetch_unit_next_pc_sel u_next_pc_sel (
    .pc_plus4     (pc_plus4),
    .se_immediate (se_immediate),
    .instr_index  (instr_q[25:0]),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .jr_addr      (jr_addr),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // started_q keeps the request low for the first cycle out of reset, which also
  // discards any ack still in flight from before the reset.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    fetch_done  = 1'b0;
    req_wait    = 1'b0;
    timeout_hit = 1'b0;
    retire_ok   = 1'b0;
    retire_bad  = 1'b0;
    case (state_q)
      ST_REQ: begin
        imem_req    = started_q;
        fetch_done  = started_q && imem_ack;
        req_wait    = started_q && !imem_ack;
        timeout_hit = req_wait && (to_cnt_q == TO_LAST);
        if (fetch_done) begin
          state_d = ST_HOLD;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_HOLD: begin
        retire_ok  = advance && !stall && !misaligned;
        retire_bad = advance && !stall && misaligned;
        if (retire_bad) begin
          state_d = ST_FAULT;
        end else if (retire_ok) begin
          state_d = ST_REQ;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q     <= 1'b0;
      to_cnt_q      <= '0;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= 1'b0;
    end else begin
      started_q <= 1'b1;

      if (fetch_done) begin
        instr_q       <= imem_rdata;
        instr_valid_q <= 1'b1;
        to_cnt_q      <= '0;
      end else if (req_wait) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (timeout_hit) begin
        fault_q <= 1'b1;
        cause_q <= FAULT_TIMEOUT;
      end

      if (retire_ok) begin
        pc_q          <= next_pc;
        instr_valid_q <= 1'b0;
      end

      // A misaligned jr target leaves pc on the offending instruction for debug.
      if (retire_bad) begin
        fault_q       <= 1'b1;
        cause_q       <= FAULT_MISALIGN;
        instr_valid_q <= 1'b0;
      end
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'(WORD_BYTES);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign immediate   = instr_q[15:0];
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

endmodule
